// File: rtl/piece_pkg.sv
// Shared types for the falling-piece mover: FSM states, move kinds and rotation.
package piece_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSpawn,
      StWait,
      StCheck,
      StCommit,
      StLock
   } state_e;

   typedef enum logic [2:0] {
      MvSpawn,
      MvDown,
      MvLeft,
      MvRight,
      MvRot
   } move_t;

   typedef logic [1:0] rot_t;

   function automatic rot_t rot_next(rot_t r);
      return r + 2'd1;
   endfunction

endpackage

// File: rtl/drop_timer.sv
// Gravity timer: counts frame ticks and raises a pending-gravity flag at the step threshold.
module drop_timer #(
   parameter int unsigned DropTicks = 30
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic count_en_i,
   input  logic tick_i,
   input  logic soft_drop_i,
   input  logic clr_cnt_i,
   input  logic clr_pend_i,
   output logic pend_o
);

   localparam int unsigned CntW = $clog2(DropTicks);
   localparam logic [CntW-1:0] MaxCnt = CntW'(DropTicks - 1);

   logic [CntW-1:0] cnt_q, cnt_d, thresh;
   logic            pend_q, pend_d;

   always_comb begin
      thresh = soft_drop_i ? '0 : MaxCnt;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (clr_pend_i) pend_d = 1'b0;
      // A threshold hit in the same cycle as a clear still leaves a fresh step pending.
      if (clr_cnt_i) begin
         cnt_d  = '0;
         pend_d = 1'b0;
      end else if (count_en_i && tick_i) begin
         if (cnt_q >= thresh) begin
            cnt_d  = '0;
            pend_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/piece_mover.sv
// Active-piece position/rotation owner with gravity and board-validated moves.
// Define PIECE_ROTATE_EN to enable rotation; otherwise rot and cand_rot stay 0.
module piece_mover
   import piece_pkg::*;
#(
   parameter int unsigned BOARD_W    = 10,
   parameter int unsigned BOARD_H    = 20,
   parameter int unsigned POS_W      = 5,
   parameter int unsigned DROP_TICKS = 30,
   parameter int unsigned SPAWN_X    = 4
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             tick,
   input  logic             shift_left,
   input  logic             shift_right,
   input  logic             rotate,
   input  logic             soft_drop,
   output logic             cand_valid,
   output logic [POS_W-1:0] cand_x,
   output logic [POS_W-1:0] cand_y,
   output logic [1:0]       cand_rot,
   input  logic             cand_done,
   input  logic             cand_ok,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output logic [1:0]       rot,
   output logic             placed,
   output logic             game_over,
   output logic             Ready
);

   localparam logic [POS_W-1:0] XMax   = POS_W'(BOARD_W - 1);
   localparam logic [POS_W-1:0] YMax   = POS_W'(BOARD_H - 1);
   localparam logic [POS_W-1:0] SpawnX = POS_W'(SPAWN_X);

   state_e           state_q, state_d;
   move_t            move_q, move_d;
   logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [POS_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
   rot_t             rot_q, rot_d, cand_rot_q, cand_rot_d;
   logic             cand_valid_q, cand_valid_d, placed_q, placed_d;
   logic             game_over_q, game_over_d, ready_q, ready_d;
   logic             grav_pend, clr_cnt, clr_pend, count_en, rot_req;

`ifdef PIECE_ROTATE_EN
   assign rot_req = rotate;
`else
   logic unused_rotate;
   assign unused_rotate = rotate;
   assign rot_req       = 1'b0;
`endif

   assign count_en = (state_q == StWait) || (state_q == StCheck) || (state_q == StCommit);

   drop_timer #(
      .DropTicks(DROP_TICKS)
   ) u_drop_timer (
      .clk_i      (clk),
      .rst_ni     (Reset_n),
      .count_en_i (count_en),
      .tick_i     (tick),
      .soft_drop_i(soft_drop),
      .clr_cnt_i  (clr_cnt),
      .clr_pend_i (clr_pend),
      .pend_o     (grav_pend)
   );

   always_comb begin
      state_d     = state_q;
      move_d      = move_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      rot_d       = rot_q;
      cand_x_d    = cand_x_q;
      cand_y_d    = cand_y_q;
      cand_rot_d  = cand_rot_q;
      game_over_d = game_over_q;
      clr_cnt     = 1'b0;
      clr_pend    = 1'b0;
      unique case (state_q)
         StIdle: if (Start && !game_over_q) state_d = StSpawn;
         StSpawn: begin
            cand_x_d   = SpawnX;
            cand_y_d   = '0;
            cand_rot_d = '0;
            move_d     = MvSpawn;
            clr_cnt    = 1'b1;
            state_d    = StCheck;
         end
         StWait: begin
            // Arbitration: gravity > left > right > rotate; losers are dropped.
            if (grav_pend) begin
               clr_pend = 1'b1;
               if (pos_y_q == YMax) begin
                  state_d = StLock;
               end else begin
                  {cand_x_d, cand_y_d, cand_rot_d} = {pos_x_q, pos_y_q + 1'b1, rot_q};
                  move_d  = MvDown;
                  state_d = StCheck;
               end
            end else if (shift_left) begin
               if (pos_x_q != '0) begin
                  {cand_x_d, cand_y_d, cand_rot_d} = {pos_x_q - 1'b1, pos_y_q, rot_q};
                  move_d  = MvLeft;
                  state_d = StCheck;
               end
            end else if (shift_right) begin
               if (pos_x_q != XMax) begin
                  {cand_x_d, cand_y_d, cand_rot_d} = {pos_x_q + 1'b1, pos_y_q, rot_q};
                  move_d  = MvRight;
                  state_d = StCheck;
               end
            end else if (rot_req) begin
               {cand_x_d, cand_y_d, cand_rot_d} = {pos_x_q, pos_y_q, rot_next(rot_q)};
               move_d  = MvRot;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (cand_done) begin
               if (cand_ok) begin
                  {pos_x_d, pos_y_d, rot_d} = {cand_x_q, cand_y_q, cand_rot_q};
                  state_d = StCommit;
               end else if (move_q == MvDown) begin
                  state_d = StLock;
               end else if (move_q == MvSpawn) begin
                  game_over_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StCommit: state_d = StWait;
         StLock:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      cand_valid_d = (state_d == StCheck);
      placed_d     = (state_d == StLock);
      ready_d      = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= StIdle;
         move_q       <= MvSpawn;
         pos_x_q      <= SpawnX;
         pos_y_q      <= '0;
         rot_q        <= '0;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         cand_rot_q   <= '0;
         cand_valid_q <= 1'b0;
         placed_q     <= 1'b0;
         game_over_q  <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         move_q       <= move_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         rot_q        <= rot_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         cand_rot_q   <= cand_rot_d;
         cand_valid_q <= cand_valid_d;
         placed_q     <= placed_d;
         game_over_q  <= game_over_d;
         ready_q      <= ready_d;
      end
   end

   assign cand_valid = cand_valid_q;
   assign cand_x     = cand_x_q;
   assign cand_y     = cand_y_q;
   assign cand_rot   = cand_rot_q;
   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign rot        = rot_q;
   assign placed     = placed_q;
   assign game_over  = game_over_q;
   assign Ready      = ready_q;

endmodule

// File: tb/tb_piece_mover.sv
// Directed self-checking bench for piece_mover; expected candidates go through a scoreboard queue.
module tb_piece_mover;

   localparam int unsigned PW = 5;

   typedef struct packed {
      logic [PW-1:0] x;
      logic [PW-1:0] y;
      logic [1:0]    r;
   } cand_s;

   logic          clk = 1'b0;
   logic          Reset_n, Start, tick, shift_left, shift_right, rotate, soft_drop;
   logic          cand_done, cand_ok, cand_valid, placed, game_over, Ready;
   logic [PW-1:0] cand_x, cand_y, pos_x, pos_y;
   logic [1:0]    cand_rot, rot;

   int            n_cmp = 0;
   int            n_bad = 0;
   cand_s         exp_q[$];
   logic [PW-1:0] ex, ey;
   logic [1:0]    er;

   always #5 clk = ~clk;

   piece_mover dut (
      .clk        (clk),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .tick       (tick),
      .shift_left (shift_left),
      .shift_right(shift_right),
      .rotate     (rotate),
      .soft_drop  (soft_drop),
      .cand_valid (cand_valid),
      .cand_x     (cand_x),
      .cand_y     (cand_y),
      .cand_rot   (cand_rot),
      .cand_done  (cand_done),
      .cand_ok    (cand_ok),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .rot        (rot),
      .placed     (placed),
      .game_over  (game_over),
      .Ready      (Ready)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [PW-1:0] x, input logic [PW-1:0] y, input logic [1:0] r);
      cand_s c;
      c.x = x;
      c.y = y;
      c.r = r;
      exp_q.push_back(c);
   endtask

   // Waits for a request, scores it, then answers two cycles later.
   task automatic answer(input string tag, input logic ok);
      cand_s e;
      int    k = 0;
      while (cand_valid !== 1'b1 && k < 20) begin
         cyc();
         k++;
      end
      e = exp_q.pop_front();
      chk({tag, " cand_valid"}, cand_valid, 1);
      chk({tag, " cand_x"}, cand_x, e.x);
      chk({tag, " cand_y"}, cand_y, e.y);
      chk({tag, " cand_rot"}, cand_rot, e.r);
      cyc(2);
      chk({tag, " held valid"}, cand_valid, 1);
      chk({tag, " held x"}, cand_x, e.x);
      cand_done = 1'b1;
      cand_ok   = ok;
      cyc();
      cand_done = 1'b0;
      cand_ok   = 1'b0;
      chk({tag, " valid drop"}, cand_valid, 0);
      if (ok) cyc();
   endtask

   task automatic wait_placed(input string tag, input logic no_cv);
      int   k  = 0;
      logic cv = 1'b0;
      while (placed !== 1'b1 && k < 40) begin
         cv = cv | cand_valid;
         cyc();
         k++;
      end
      chk({tag, " placed"}, placed, 1);
      if (no_cv) chk({tag, " no cand_valid"}, cv, 0);
      cyc();
      chk({tag, " placed one cycle"}, placed, 0);
      chk({tag, " Ready after lock"}, Ready, 1);
   endtask

   task automatic grav_step(input string tag, input logic ok);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      push(ex, ey + 1'b1, er);
      answer(tag, ok);
      if (ok) ey = ey + 1'b1;
   endtask

   task automatic spawn_ok();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      chk("Ready falls", Ready, 0);
      push(5'd4, 5'd0, 2'd0);
      answer("spawn", 1'b1);
      ex = 5'd4;
      ey = 5'd0;
      er = 2'd0;
      chk("spawn pos_x", pos_x, 4);
      chk("spawn pos_y", pos_y, 0);
      chk("spawn Ready", Ready, 0);
   endtask

   initial begin
      {Start, tick, shift_left, shift_right, rotate, soft_drop, cand_done, cand_ok} = '0;
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #1;
      chk("rst pos_x", pos_x, 4);
      chk("rst pos_y", pos_y, 0);
      chk("rst rot", rot, 0);
      chk("rst Ready", Ready, 1);
      chk("rst cand_valid", cand_valid, 0);
      chk("rst placed", placed, 0);
      chk("rst game_over", game_over, 0);
      cyc(2);
      Reset_n = 1'b1;
      cyc();

      spawn_ok();

      // Soft drop: one gravity step per tick all the way down, then lock without a check.
      soft_drop = 1'b1;
      for (int y = 0; y < 19; y++) begin
         grav_step("soft drop", 1'b1);
         chk("soft drop pos_y", pos_y, ey);
      end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      wait_placed("bottom lock", 1'b1);
      chk("bottom pos_y", pos_y, 19);
      soft_drop = 1'b0;

      spawn_ok();
      for (int i = 0; i < 4; i++) begin
         shift_left = 1'b1;
         cyc();
         shift_left = 1'b0;
         push(ex - 1'b1, ey, er);
         answer("left", 1'b1);
         ex = ex - 1'b1;
         chk("left pos_x", pos_x, ex);
      end
      shift_left = 1'b1;
      cyc();
      shift_left = 1'b0;
      for (int i = 0; i < 3; i++) chk("left edge no check", cand_valid, 0);
      chk("left edge pos_x", pos_x, 0);
      shift_right = 1'b1;
      cyc();
      shift_right = 1'b0;
      push(5'd1, ey, er);
      answer("right reject", 1'b0);
      chk("right reject pos_x", pos_x, 0);
      chk("right reject no lock", placed, 0);
      cyc();
      chk("right reject no lock late", placed, 0);

`ifdef PIECE_ROTATE_EN
      for (int i = 0; i < 4; i++) begin
         rotate = 1'b1;
         cyc();
         rotate = 1'b0;
         push(ex, ey, er + 2'd1);
         answer("rotate", 1'b1);
         er = er + 2'd1;
         chk("rotate rot", rot, er);
      end
`else
      rotate = 1'b1;
      cyc();
      rotate = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rotate ignored", cand_valid, 0);
         cyc();
      end
      chk("rotate rot", rot, 0);
`endif

      // Gravity rejected at y=7 locks in place.
      soft_drop = 1'b1;
      for (int i = 0; i < 7; i++) grav_step("drop to 7", 1'b1);
      chk("pre-lock pos_y", pos_y, 7);
      grav_step("gravity reject", 1'b0);
      wait_placed("gravity lock", 1'b0);
      chk("gravity lock pos_y", pos_y, 7);
      soft_drop = 1'b0;

      // Rejected spawn ends the game until reset.
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      push(5'd4, 5'd0, 2'd0);
      answer("spawn reject", 1'b0);
      chk("game_over set", game_over, 1);
      chk("game_over Ready", Ready, 1);
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      cyc(2);
      chk("start ignored Ready", Ready, 1);
      chk("start ignored check", cand_valid, 0);
      Reset_n = 1'b0;
      #1;
      chk("reset clears game_over", game_over, 0);
      chk("reset pos_x", pos_x, 4);
      chk("reset pos_y", pos_y, 0);
      cyc();
      Reset_n = 1'b1;
      cyc();

      // Reset during a check, then a stale response.
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      cyc();
      chk("mid-check valid", cand_valid, 1);
      Reset_n = 1'b0;
      #1;
      chk("mid reset valid", cand_valid, 0);
      chk("mid reset Ready", Ready, 1);
      cyc();
      Reset_n   = 1'b1;
      cand_done = 1'b1;
      cand_ok   = 1'b1;
      cyc();
      cand_done = 1'b0;
      cand_ok   = 1'b0;
      cyc();
      chk("late done Ready", Ready, 1);
      chk("late done valid", cand_valid, 0);
      chk("late done pos_y", pos_y, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/piece_mover.md
# piece_mover

Parametrised successor to the single-position falling-piece block. Owns the active piece's position and rotation, runs a tick-driven gravity timer with soft drop, and turns move requests into candidate positions. Each candidate is validated by the board memory over a request/done handshake before it is committed. Sits between the input debouncers/frame-tick generator and the board/collision logic.

## Interface
Parameters:
- BOARD_W, 10, playfield columns
- BOARD_H, 20, playfield rows
- POS_W, 5, width of pos_x/pos_y; must hold max(BOARD_W, BOARD_H)-1
- DROP_TICKS, 30, frame ticks per gravity step (≥2)
- SPAWN_X, 4, spawn column (< BOARD_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  pulse; spawn a new piece (honoured only when Ready)
- tick  in  1  one-cycle frame strobe
- shift_left / shift_right / rotate  in  1 each  one-cycle move pulses
- soft_drop  in  1  level; gravity period becomes 1 tick
- cand_valid  out  1  candidate check request
- cand_x, cand_y  out  POS_W  candidate position
- cand_rot  out  2  candidate rotation
- cand_done  in  1  board response strobe
- cand_ok  in  1  candidate is legal (qualified by cand_done)
- pos_x, pos_y  out  POS_W  committed position
- rot  out  2  committed rotation
- placed  out  1  one-cycle pulse when the piece locks
- game_over  out  1  sticky; spawn position rejected
- Ready  out  1  idle, awaiting Start

## Operation
- Reset values: pos_x=SPAWN_X, pos_y=0, rot=0, Ready=1, all other outputs 0; state IDLE; drop counter 0.
- States and transitions:
  - IDLE: Start & !game_over -> SPAWN.
  - SPAWN: loads (SPAWN_X, 0, 0) into the candidate -> CHECK(spawn).
  - WAIT: accepts requests -> CHECK, or -> LOCK directly.
  - CHECK: waits for the board response.
  - COMMIT: writes the candidate into the committed position -> WAIT.
  - LOCK: asserts placed -> IDLE.
- Move arbitration in WAIT, one move per visit, priority gravity > left > right > rotate. Losing pulses are dropped, not queued.
- Local rejects (no check issued, stay in WAIT):
  - left with pos_x=0
  - right with pos_x=BOARD_W-1
- Gravity with pos_y=BOARD_H-1 goes straight to LOCK.
- Candidate computation: down = y+1; left = x-1; right = x+1; rotate = rot+1 mod 4 (wraps 3->0).
- Check results:
  - cand_ok=1: COMMIT.
  - cand_ok=0 on a gravity move: LOCK.
  - cand_ok=0 on another move: WAIT, position unchanged.
  - cand_ok=0 on the spawn check: game_over=1, then IDLE. game_over clears only on reset.
- Drop counter counts tick pulses while in WAIT/CHECK/COMMIT. The step threshold is DROP_TICKS-1, or 0 while soft_drop is high.
  - Reaching the threshold sets a pending gravity flag and zeroes the counter.
  - The flag clears when a gravity check is issued.
  - The counter clears on spawn.
- Start outside IDLE, and move pulses outside WAIT, are ignored.

## Timing
- Ready is high in IDLE only. Ready falls the cycle after Start is accepted.
- Request sampled in WAIT at cycle n -> cand_valid high from n+1.
- cand_valid and cand_* stay stable until the cycle cand_done is sampled high. cand_valid drops the following cycle.
- cand_done with cand_ok at cycle m -> pos/rot updated at m+1, back in WAIT at m+2.
- Lock: placed is high for exactly one cycle. Ready rises the following cycle.
- tick and a move request in the same cycle: both are honoured. The tick is counted, and the move is arbitrated against any already-pending gravity.
- Reset_n asserted mid-check immediately returns all outputs to their reset values. A late cand_done after reset is ignored.

## Configuration
- PIECE_ROTATE_EN defined: rotate is arbitrated as above and rot tracks commits.
- PIECE_ROTATE_EN undefined: rotate is ignored, rot and cand_rot are tied to 0, and no rotate checks are ever issued.

## Structure
- Package piece_pkg holds:
  - state enum (IDLE, SPAWN, WAIT, CHECK, COMMIT, LOCK)
  - move_t enum (MV_SPAWN, MV_DOWN, MV_LEFT, MV_RIGHT, MV_ROT)
  - rot_t (2-bit)
- Sub-module drop_timer: tick counter, threshold compare, soft_drop select, pending-gravity flag with clear input.

## Test plan
- Reset, Start, cand_done/cand_ok=1 two cycles after cand_valid -> pos=(4,0), WAIT; Ready low.
- soft_drop held with board always ok -> pos_y steps 0..19, one step per tick. The next gravity at y=19 gives placed pulse with no cand_valid, then Ready.
- At pos_x=0 pulse shift_left -> no cand_valid, pos_x stays 0. Pulse shift_right with cand_ok=0 -> pos_x unchanged, no lock.
- Gravity check answered cand_ok=0 at y=7 -> placed one cycle, pos_y=7 held, Ready next cycle.
- Spawn check answered cand_ok=0 -> game_over=1, Ready=1. A following Start is ignored until Reset_n is pulsed low.
- PIECE_ROTATE_EN defined: four accepted rotates -> rot 1,2,3,0. Undefined: rotate pulses produce no cand_valid.
